coherence_control: RTL and testbench

COHERENCE_CONTROL -- requirements
Module: coherence_control

---
 rtl/coherence_control.sv | 161 ++++++++++++++++
 tb/tb_coherence_control.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_control.sv
// Two-core coherence controller: arbitrates fetch, writeback and snooped data traffic onto one RAM port.
// Optional CCIF_RR_EN selects round-robin tie-breaking; otherwise core 0 wins ties.
module coherence_control #(
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [1:0]             iREN,
  input  logic [1:0][DATA_W-1:0] iaddr,
  output logic [1:0]             iwait,
  output logic [1:0][DATA_W-1:0] iload,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][DATA_W-1:0] daddr,
  input  logic [1:0][DATA_W-1:0] dstore,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             dwait,
  output logic [1:0][DATA_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][DATA_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [DATA_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  input  logic [DATA_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  typedef enum logic [2:0] {IDLE, IFETCH, WB, SNOOP, XFER1, XFER2, READ1, READ2} state_t;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_q, state_d;
  logic   req_q, req_d;
  logic   ptr_q, ptr_d;
  logic   armed_q, armed_d;

  logic       snp, access, pri, win;
  logic [1:0] wb_req, sn_req, cand;

  function automatic logic pick(input logic [1:0] c, input logic p);
    if (c == 2'b11) return p;
    return c[1];
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      ptr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ptr_q   <= ptr_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    ptr_d       = ptr_q;
    armed_d     = 1'b0;
    iwait       = 2'b11;
    dwait       = 2'b11;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    snp    = ~req_q;
    access = (ramstate == RAM_ACCESS);
    wb_req = dWEN & ~cctrans;
    sn_req = (dREN | dWEN) & cctrans;
    cand   = (|wb_req) ? wb_req : (|sn_req) ? sn_req : iREN;
`ifdef CCIF_RR_EN
    pri = ptr_q;
`else
    pri = 1'b0;
`endif
    win = pick(cand, pri);

    // Snooped core sees the request for the whole coherence transaction
    if (state_q inside {SNOOP, XFER1, XFER2, READ1, READ2}) begin
      ccwait[snp]      = 1'b1;
      ccsnoopaddr[snp] = daddr[req_q];
      ccinv[snp]       = ccwrite[req_q];
    end

    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          req_d   = win;
`ifdef CCIF_RR_EN
          ptr_d   = ~win;
`endif
          state_d = (|wb_req) ? WB : (|sn_req) ? SNOOP : IFETCH;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[req_q];
        if (access) begin
          iload[req_q] = ramload;
          iwait[req_q] = 1'b0;
          state_d      = IDLE;
        end
      end
      WB: begin
        // Write only while the cache still holds dWEN so no stale word lands in RAM
        if (dWEN[req_q]) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[req_q];
          ramstore = dstore[req_q];
          if (access) dwait[req_q] = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SNOOP: begin
        armed_d = 1'b1;
        if (armed_q) begin
          armed_d = 1'b0;
          state_d = ccwrite[snp] ? XFER1 : READ1;
        end
      end
      XFER1, XFER2: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[req_q];
        ramstore     = dstore[snp];
        dload[req_q] = dstore[snp];
        if (access) begin
          dwait   = 2'b00;
          state_d = (state_q == XFER1) ? XFER2 : IDLE;
        end
      end
      READ1, READ2: begin
        ramREN       = 1'b1;
        ramaddr      = daddr[req_q];
        dload[req_q] = ramload;
        if (dWEN[req_q]) begin
          ramWEN   = 1'b1;
          ramstore = dstore[req_q];
        end
        if (access) begin
          dwait[req_q] = 1'b0;
          state_d      = (state_q == READ1) ? READ2 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_control.sv
// Randomized self-checking bench for coherence_control; expectations come from a transaction-level model.
module tb_coherence_control;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic             CLK, nRST;
  logic [1:0]       iREN, dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;

  coherence_control dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [1:0] onehot(input int c);
    return (c == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] busy_val();
    case ($urandom_range(0, 2))
      0: return FREE;
      1: return BUSY;
      default: return ERR;
    endcase
  endfunction

  // Winner among simultaneously requesting cores, then the pointer moves past it.
  function automatic int grant(input logic [1:0] c);
    int w;
    if (c == 2'b11) begin
`ifdef CCIF_RR_EN
      w = exp_ptr;
`else
      w = 0;
`endif
    end else begin
      w = c[1] ? 1 : 0;
    end
    exp_ptr = 1 - w;
    return w;
  endfunction

  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    iREN = 2'b11; dREN = 2'b11; cctrans = 2'b11; ramstate = ACC; ramload = 32'hA5A5A5A5;
    @(negedge CLK); #1;
    checks++; if ({dwait, iwait} !== 4'hF) begin errors++; $display("FAIL reset_wait: got %b expected 1111", {dwait, iwait}); end
    checks++; if ({ccwait, ccinv, ramREN, ramWEN} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {ccwait, ccinv, ramREN, ramWEN}); end
    checks++; if ({iload, dload, ccsnoopaddr, ramaddr, ramstore} !== '0) begin errors++; $display("FAIL reset_data: got nonzero data outputs expected 0"); end
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;
    exp_ptr = 0;
    #1;
    checks++; if ({dwait, iwait, ramREN, ramWEN} !== 6'b111100) begin errors++; $display("FAIL reset_release: got %b expected 111100", {dwait, iwait, ramREN, ramWEN}); end
  endtask

  task automatic test_fetch(input int iters);
    int c, nb;
    logic [31:0] a, v;
    for (int k = 0; k < iters; k++) begin
      c = (k == 0) ? 0 : int'($urandom_range(0, 1));
      a = (k == 0) ? 32'h100 : ($urandom & 32'hFFFC);
      nb = (k == 0) ? 2 : int'($urandom_range(0, 3));
      v = $urandom;
      @(negedge CLK);
      idle_inputs(); iREN[c] = 1'b1; iaddr[c] = a; iaddr[1-c] = $urandom;
      void'(grant(onehot(c)));
      #1;
      checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL fetch_idle: ramREN=%b expected 0", ramREN); end
      for (int b = 0; b <= nb; b++) begin
        @(negedge CLK);
        ramstate = (b == nb) ? ACC : ((k == 0) ? BUSY : busy_val());
        ramload = v;
        #1;
        if (b < nb) begin
          checks++; if ({ramREN, ramaddr, iwait} !== {1'b1, a, 2'b11}) begin errors++; $display("FAIL fetch_stall: got %b/%h/%b expected 1/%h/11", ramREN, ramaddr, iwait, a); end
        end else begin
          checks++; if ({ramREN, ramaddr, iwait, iload[c]} !== {1'b1, a, ~onehot(c), v}) begin errors++; $display("FAIL fetch_access: got %b/%h/%b/%h expected 1/%h/%b/%h", ramREN, ramaddr, iwait, iload[c], a, ~onehot(c), v); end
        end
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      checks++; if ({iwait, ramREN} !== 3'b110) begin errors++; $display("FAIL fetch_done: got %b expected 110", {iwait, ramREN}); end
    end
  endtask

  task automatic test_writeback(input int iters);
    int c, nb;
    logic [31:0] a, d;
    for (int k = 0; k < iters; k++) begin
      c = (k == 0) ? 1 : int'($urandom_range(0, 1));
      a = (k == 0) ? 32'h208 : ($urandom & 32'hFFFC);
      d = (k == 0) ? 32'hDEADBEEF : $urandom;
      @(negedge CLK);
      idle_inputs(); dWEN[c] = 1'b1; daddr[c] = a; dstore[c] = d;
      void'(grant(onehot(c)));
      #1;
      checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL wb_idle: ramWEN=%b expected 0", ramWEN); end
      for (int w = 0; w < 2; w++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b <= nb; b++) begin
          @(negedge CLK);
          if (w > 0 && b == 0) begin a = a + 4; d = $urandom; daddr[c] = a; dstore[c] = d; end
          ramstate = (b == nb) ? ACC : busy_val();
          #1;
          checks++;
          if ({ramWEN, ramaddr, ramstore, dwait, ccwait} !== {1'b1, a, d, ((b == nb) ? ~onehot(c) : 2'b11), 2'b00}) begin
            errors++; $display("FAIL wb_word: got %b/%h/%h/%b/%b expected 1/%h/%h/%b/00", ramWEN, ramaddr, ramstore, dwait, ccwait, a, d, (b == nb) ? ~onehot(c) : 2'b11);
          end
        end
      end
      @(negedge CLK);
      idle_inputs();
      @(negedge CLK); #1;
      checks++; if ({ramWEN, dwait, ccwait} !== 5'b01100) begin errors++; $display("FAIL wb_done: got %b expected 01100", {ramWEN, dwait, ccwait}); end
    end
  endtask

  task automatic test_snoop_read(input int iters);
    int c, s, nb;
    bit got, wr, inv;
    logic [31:0] a, v, st;
    for (int k = 0; k < iters; k++) begin
      c = (k == 0) ? 0 : int'($urandom_range(0, 1));
      s = 1 - c;
      wr = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      inv = wr ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom & 32'hFFFC;
      st = $urandom;
      @(negedge CLK);
      idle_inputs();
      cctrans[c] = 1'b1; daddr[c] = a; dstore[c] = st; ccwrite[c] = inv;
      if (wr) dWEN[c] = 1'b1; else dREN[c] = 1'b1;
      void'(grant(onehot(c)));
      #1;
      checks++; if (ccwait !== 2'b00) begin errors++; $display("FAIL snp_idle: ccwait=%b expected 00", ccwait); end
      got = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge CLK); #1;
        checks++;
        if ({ccwait, ccsnoopaddr[s], ccinv} !== {onehot(s), a, (inv ? onehot(s) : 2'b00)}) begin
          errors++; $display("FAIL snp_hold: got %b/%h/%b expected %b/%h/%b", ccwait, ccsnoopaddr[s], ccinv, onehot(s), a, inv ? onehot(s) : 2'b00);
        end
        if (ramREN) begin got = 1; break; end
      end
      if (!got) begin errors++; checks++; $display("FAIL snp_timeout: ramREN=0 expected 1 within 6 cycles"); idle_inputs(); return; end
      for (int w = 0; w < 2; w++) begin
        nb = $urandom_range(0, 2);
        v = $urandom;
        for (int b = 0; b <= nb; b++) begin
          @(negedge CLK);
          ramstate = (b == nb) ? ACC : busy_val();
          ramload = v;
          #1;
          checks++;
          if ({ramREN, ramWEN, ramaddr, ramstore, dload[c], dwait, ccwait} !==
              {1'b1, wr, a, (wr ? st : 32'h0), v, ((b == nb) ? ~onehot(c) : 2'b11), onehot(s)}) begin
            errors++; $display("FAIL snp_read: got %b%b/%h/%h/%h/%b/%b expected 1%b/%h/%h/%h/%b/%b", ramREN, ramWEN, ramaddr, ramstore, dload[c], dwait, ccwait,
                               wr, a, wr ? st : 32'h0, v, (b == nb) ? ~onehot(c) : 2'b11, onehot(s));
          end
        end
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      checks++; if ({ccwait, ramREN, dwait} !== 5'b00011) begin errors++; $display("FAIL snp_done: got %b expected 00011", {ccwait, ramREN, dwait}); end
    end
  endtask

  task automatic test_xfer(input int iters, input bit reset_in_xfer2);
    int c, s, nb;
    bit got;
    logic [31:0] a, d;
    for (int k = 0; k < iters; k++) begin
      c = (k == 0) ? 0 : int'($urandom_range(0, 1));
      s = 1 - c;
      a = $urandom & 32'hFFFC;
      d = (k == 0) ? 32'h1234 : $urandom;
      @(negedge CLK);
      idle_inputs();
      dWEN[c] = 1'b1; cctrans[c] = 1'b1; ccwrite[c] = 1'b1; daddr[c] = a; dstore[c] = $urandom;
      ccwrite[s] = 1'b1; dstore[s] = d;
      void'(grant(onehot(c)));
      got = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge CLK); #1;
        checks++;
        if ({ccwait, ccinv} !== {onehot(s), onehot(s)}) begin errors++; $display("FAIL xfer_inv: got %b/%b expected %b/%b", ccwait, ccinv, onehot(s), onehot(s)); end
        if (ramWEN) begin got = 1; break; end
      end
      if (!got) begin errors++; checks++; $display("FAIL xfer_timeout: ramWEN=0 expected 1 within 6 cycles"); idle_inputs(); return; end
      for (int w = 0; w < 2; w++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b <= nb; b++) begin
          @(negedge CLK);
          if (w > 0 && b == 0) begin d = $urandom; dstore[s] = d; end
          ramstate = (b == nb) ? ACC : busy_val();
          #1;
          checks++;
          if ({ramWEN, ramREN, ramaddr, ramstore, dload[c], dwait} !== {1'b1, 1'b0, a, d, d, ((b == nb) ? 2'b00 : 2'b11)}) begin
            errors++; $display("FAIL xfer_word: got %b%b/%h/%h/%h/%b expected 10/%h/%h/%h/%b", ramWEN, ramREN, ramaddr, ramstore, dload[c], dwait, a, d, d, (b == nb) ? 2'b00 : 2'b11);
          end
        end
        if (reset_in_xfer2 && w == 0) begin
          @(negedge CLK);
          ramstate = ACC;
          nRST = 1'b0;
          #1;
          checks++; if ({ramWEN, ramREN, ccwait, ccinv, dwait, dload[c]} !== {1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 32'h0}) begin
            errors++; $display("FAIL xfer2_reset: got %b%b/%b/%b/%b/%h expected 00/00/00/11/0", ramWEN, ramREN, ccwait, ccinv, dwait, dload[c]);
          end
          @(negedge CLK);
          idle_inputs();
          nRST = 1'b1;
          exp_ptr = 0;
          #1;
          checks++; if ({ramWEN, ramREN, ccwait, dwait} !== 6'b000011) begin errors++; $display("FAIL xfer2_after_reset: got %b expected 000011", {ramWEN, ramREN, ccwait, dwait}); end
          return;
        end
      end
      @(negedge CLK);
      idle_inputs();
      #1;
      checks++; if ({ccwait, ccinv, ramWEN} !== 5'b00000) begin errors++; $display("FAIL xfer_done: got %b expected 00000", {ccwait, ccinv, ramWEN}); end
    end
  endtask

  task automatic test_priority();
    bit got;
    logic [31:0] ia, da, dd, v;
    ia = $urandom & 32'hFFFC; da = $urandom & 32'hFFFC; dd = $urandom; v = $urandom;
    @(negedge CLK);
    idle_inputs();
    iREN[0] = 1'b1; iaddr[0] = ia;
    dWEN[1] = 1'b1; daddr[1] = da; dstore[1] = dd;
    void'(grant(2'b10));
    @(negedge CLK);
    ramstate = ACC;
    #1;
    checks++; if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait} !== {1'b1, 1'b0, da, dd, 2'b01, 2'b11}) begin
      errors++; $display("FAIL prio_wb_first: got %b%b/%h/%h/%b/%b expected 10/%h/%h/01/11", ramWEN, ramREN, ramaddr, ramstore, dwait, iwait, da, dd);
    end
    @(negedge CLK);
    dWEN[1] = 1'b0; ramstate = FREE;
    void'(grant(2'b01));
    got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge CLK); #1;
      if (ramREN) begin got = 1; break; end
    end
    if (!got) begin errors++; checks++; $display("FAIL prio_fetch_timeout: ramREN=0 expected 1 within 6 cycles"); idle_inputs(); return; end
    ramstate = ACC; ramload = v;
    #1;
    checks++; if ({ramaddr, iwait, iload[0]} !== {ia, 2'b10, v}) begin errors++; $display("FAIL prio_fetch: got %h/%b/%h expected %h/10/%h", ramaddr, iwait, iload[0], ia, v); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_contention(input int n);
    int w;
    bit got;
    logic [31:0] v;
    @(negedge CLK);
    idle_inputs();
    dREN = 2'b11; cctrans = 2'b11;
    daddr[0] = $urandom & 32'hFFFC; daddr[1] = $urandom & 32'hFFFC;
    for (int t = 0; t < n; t++) begin
      got = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge CLK); #1;
        if (ccwait != 2'b00) begin got = 1; break; end
      end
      if (!got) begin errors++; checks++; $display("FAIL cont_timeout: ccwait=00 expected a snoop within 6 cycles"); idle_inputs(); return; end
      w = grant(2'b11);
      checks++; if (ccwait !== onehot(1 - w)) begin errors++; $display("FAIL cont_grant%0d: ccwait=%b expected %b", t, ccwait, onehot(1 - w)); end
      got = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
        if (ramREN) begin got = 1; break; end
        @(negedge CLK); #1;
      end
      if (!got) begin errors++; checks++; $display("FAIL cont_read_timeout: ramREN=0 expected 1"); idle_inputs(); return; end
      for (int k = 0; k < 2; k++) begin
        @(negedge CLK);
        v = $urandom; ramstate = ACC; ramload = v;
        #1;
        checks++; if ({ramaddr, dload[w], dwait} !== {daddr[w], v, ~onehot(w)}) begin
          errors++; $display("FAIL cont_read%0d: got %h/%h/%b expected %h/%h/%b", t, ramaddr, dload[w], dwait, daddr[w], v, ~onehot(w));
        end
      end
      @(negedge CLK);
      ramstate = FREE;
    end
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    test_reset();
    test_fetch(4);
    test_writeback(3);
    test_snoop_read(4);
    test_xfer(3, 1'b0);
    test_priority();
    test_xfer(1, 1'b1);
    test_contention(4);
    test_fetch(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
